sdram_frame_scheduler: RTL

Triple-buffer frame scheduler that configures the write-side-1 and read-side-1 ports of the 4-port SDRAM controller. It tracks which of three SDRAM frame buffers the camera is writing, which buffer the display is reading and which is the latest complete frame. At each frame boundary it reprograms the port start/max addresses and issues the port LOAD (address load and FIFO clear) pulse. The display never reads a partially written frame, and the camera never overwrites the frame being displayed.

---
 rtl/sdram_frame_scheduler.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/sdram_frame_scheduler.sv
// sdram_frame_scheduler
//   Triple-buffer frame scheduler for the write-side-1 / read-side-1 ports of
//   the 4-port SDRAM controller. Tracks the buffer being written by the
//   camera, the buffer being read by the display and the latest complete
//   frame. On each accepted vsync rising edge it reprograms the port
//   start/max addresses and pulses the port LOAD for LOAD_CYCLES clocks.
//
//   Optional feature macro: SCHED_DROP_CNT_EN adds the DROP_CNT port, a
//   saturating count of published frames replaced before the display took them.
//
// Ports
//   CLK, RESET                  controller clock, async active-high reset
//   ENABLE                      scheduling enable (low: edges ignored, frame
//                               in progress discarded)
//   WR_VS, RD_VS                camera / display vsync levels (CLK domain)
//   WR1_ADDR/MAX_ADDR/LENGTH/LOAD   write port programming
//   RD1_ADDR/MAX_ADDR/LENGTH/LOAD   read port programming
//   WR_IDX, RD_IDX              buffers currently written / read
//   FRAME_VALID                 a complete frame has been published
//   DROP_CNT                    dropped-frame count (SCHED_DROP_CNT_EN only)

// Per-side LOAD sequencer. accept is the qualified edge (only in S_RUN);
// load is the registered LOAD pulse, high for LOAD_CYCLES clocks.
module sdram_frame_scheduler_load_fsm #(
  parameter int LOAD_CYCLES = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic trig,
  output logic accept,
  output logic load
);
  typedef enum logic {S_RUN, S_LOAD} state_t;
  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      S_RUN: if (trig) begin
        accept    = 1'b1;
        state_nxt = S_LOAD;
        cnt_nxt   = 4'(LOAD_CYCLES - 1);
      end
      S_LOAD: if (cnt == 4'd0) state_nxt = S_RUN;
              else             cnt_nxt   = cnt - 4'd1;
      default: state_nxt = S_RUN;
    endcase
  end

  assign load = (state == S_LOAD);
endmodule

module sdram_frame_scheduler #(
  parameter int              ASIZE       = 23,
  parameter int              FRAME_WORDS = 640*480,
  parameter logic [ASIZE-1:0] BASE_ADDR  = '0,
  parameter logic [ASIZE-1:0] BUF_STRIDE = 23'h100000,
  parameter int              BURST_LEN   = 256,
  parameter int              LOAD_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             WR_VS,
  input  logic             RD_VS,
  output logic [ASIZE-1:0] WR1_ADDR,
  output logic [ASIZE-1:0] WR1_MAX_ADDR,
  output logic [8:0]       WR1_LENGTH,
  output logic             WR1_LOAD,
  output logic [ASIZE-1:0] RD1_ADDR,
  output logic [ASIZE-1:0] RD1_MAX_ADDR,
  output logic [8:0]       RD1_LENGTH,
  output logic             RD1_LOAD,
  output logic [1:0]       WR_IDX,
  output logic [1:0]       RD_IDX,
`ifdef SCHED_DROP_CNT_EN
  output logic [15:0]      DROP_CNT,
`endif
  output logic             FRAME_VALID
);
  localparam int SIDES = 2;  // [0] write side, [1] read side

  function automatic logic [ASIZE-1:0] buf_base(input logic [1:0] k);
    return BASE_ADDR + BUF_STRIDE * ASIZE'(k);
  endfunction

  // Lowest buffer that is neither the published frame nor the display buffer.
  function automatic logic [1:0] pick_wr(input logic lv, input logic [1:0] l,
                                         input logic [1:0] r);
    if (!(lv && l == 2'd0) && r != 2'd0)      return 2'd0;
    else if (!(lv && l == 2'd1) && r != 2'd1) return 2'd1;
    else                                      return 2'd2;
  endfunction

  logic [1:0]       wr_idx, rd_idx, latest;
  logic             latest_v, wr_active, latest_shown;
  logic [SIDES-1:0] vs_q, vs_in, side_trig, side_acc, side_load;

  assign vs_in     = {RD_VS, WR_VS};
  assign side_trig = vs_in & ~vs_q & {SIDES{ENABLE}};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) vs_q <= '0;
    else       vs_q <= vs_in;
  end

  for (genvar s = 0; s < SIDES; s++) begin : g_side
    sdram_frame_scheduler_load_fsm #(.LOAD_CYCLES(LOAD_CYCLES)) u_load (
      .CLK    (CLK),
      .RESET  (RESET),
      .trig   (side_trig[s]),
      .accept (side_acc[s]),
      .load   (side_load[s])
    );
  end

  // Next-state buffer bookkeeping. Ordering matters for simultaneous edges:
  // publish, then the read side takes the new frame, then the writer picks
  // a buffer against both updated values.
  logic [1:0] latest_n, rd_n, wr_n;
  logic       latest_v_n, shown_n, wr_active_n;
`ifdef SCHED_DROP_CNT_EN
  logic       drop;
`endif

  always_comb begin
    latest_n    = latest;
    latest_v_n  = latest_v;
    shown_n     = latest_shown;
    wr_active_n = wr_active & ENABLE;
    rd_n        = rd_idx;
    wr_n        = wr_idx;
`ifdef SCHED_DROP_CNT_EN
    drop        = 1'b0;
`endif
    if (side_acc[0]) begin
      if (wr_active) begin
`ifdef SCHED_DROP_CNT_EN
        drop       = latest_v & ~latest_shown;
`endif
        latest_n   = wr_idx;
        latest_v_n = 1'b1;
        shown_n    = 1'b0;
      end
      wr_active_n = 1'b1;
    end
    if (side_acc[1] && latest_v_n) begin
      rd_n    = latest_n;
      shown_n = 1'b1;
    end
    if (side_acc[0]) wr_n = pick_wr(latest_v_n, latest_n, rd_n);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_idx       <= 2'd0;
      rd_idx       <= 2'd2;
      latest       <= 2'd0;
      latest_v     <= 1'b0;
      latest_shown <= 1'b0;
      wr_active    <= 1'b0;
      WR1_ADDR     <= buf_base(2'd0);
      WR1_MAX_ADDR <= buf_base(2'd0) + ASIZE'(FRAME_WORDS);
      RD1_ADDR     <= buf_base(2'd2);
      RD1_MAX_ADDR <= buf_base(2'd2) + ASIZE'(FRAME_WORDS);
    end else begin
      wr_idx       <= wr_n;
      rd_idx       <= rd_n;
      latest       <= latest_n;
      latest_v     <= latest_v_n;
      latest_shown <= shown_n;
      wr_active    <= wr_active_n;
      // Addresses only move on an accepted edge, so they hold through LOAD.
      if (side_acc[0]) begin
        WR1_ADDR     <= buf_base(wr_n);
        WR1_MAX_ADDR <= buf_base(wr_n) + ASIZE'(FRAME_WORDS);
      end
      if (side_acc[1]) begin
        RD1_ADDR     <= buf_base(rd_n);
        RD1_MAX_ADDR <= buf_base(rd_n) + ASIZE'(FRAME_WORDS);
      end
    end
  end

`ifdef SCHED_DROP_CNT_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                          DROP_CNT <= '0;
    else if (drop && DROP_CNT != 16'hFFFF) DROP_CNT <= DROP_CNT + 16'd1;
  end
`endif

  assign WR1_LOAD    = side_load[0];
  assign RD1_LOAD    = side_load[1];
  assign WR1_LENGTH  = 9'(BURST_LEN);
  assign RD1_LENGTH  = 9'(BURST_LEN);
  assign WR_IDX      = wr_idx;
  assign RD_IDX      = rd_idx;
  assign FRAME_VALID = latest_v;
endmodule
